alu_mul_arb: RTL

Round-robin arbiter and sequencer that shares one sequential 16x16 multiplier (`alu_mul`) among `NREQ` requesters. It latches the winning requester's operands and pulses the multiplier's load. It then reassembles the two-phase result: low half, then high half with `valid`. The full 32-bit product and flags go back to the requester with a one-cycle acknowledge. It sits between the ALU issue logic and the multiplier instance, and provides a timeout for a hung multiplier.

---
 rtl/alu_mul_arb.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_mul_arb.sv
//==============================================================================
// Module      : alu_mul_arb
// Description : Round-robin arbiter/sequencer sharing one sequential 16x16
//               multiplier among NREQ requesters. Latches the winner's
//               operands, pulses the multiplier load, reassembles the
//               two-phase result (low half, then high half with valid) and
//               returns product, flags and a one-cycle acknowledge. Aborts
//               with an error flag if the multiplier never reports valid.
// Ports       : clk, a_reset            - clock, async active-high reset
//               req, req_signd          - per-requester request / signed sel
//               req_a, req_b            - packed operands, i at [i*DATA_WL +:]
//               ack                     - one-hot completion pulse
//               rsp_prod/z/s/err        - response, valid with ack
//               busy                    - high whenever not IDLE
//               mul_a/b/signd/ld        - multiplier operands and load pulse
//               mul_p/valid/z/s         - multiplier result and flags
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_mul_arb #(
   parameter int DATA_WL = 16,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 31
) (
   input  logic                     clk,
   input  logic                     a_reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_signd,
   input  logic [NREQ*DATA_WL-1:0]  req_a,
   input  logic [NREQ*DATA_WL-1:0]  req_b,
   output logic [NREQ-1:0]          ack,
   output logic [2*DATA_WL-1:0]     rsp_prod,
   output logic                     rsp_z,
   output logic                     rsp_s,
   output logic                     rsp_err,
   output logic                     busy,
   output logic [DATA_WL-1:0]       mul_a,
   output logic [DATA_WL-1:0]       mul_b,
   output logic                     mul_signd,
   output logic                     mul_ld,
   input  logic [DATA_WL-1:0]       mul_p,
   input  logic                     mul_valid,
   input  logic                     mul_z,
   input  logic                     mul_s
);

   localparam int C_ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int C_CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [C_ID_W-1:0]     r_last;
   logic [C_ID_W-1:0]     r_id;
   logic [DATA_WL-1:0]    r_a;
   logic [DATA_WL-1:0]    r_b;
   logic                  r_signd;
   logic [DATA_WL-1:0]    r_lo;
   logic [2*DATA_WL-1:0]  r_prod;
   logic                  r_z;
   logic                  r_s;
   logic                  r_err;
   logic [C_CNT_W-1:0]    r_cnt;

   logic                  w_any;
   logic                  w_found;
   logic [C_ID_W-1:0]     w_win;
   logic [C_ID_W-1:0]     w_sel;
   logic                  w_timeout;
   int                    v_idx;

   //---------------------------------------------------------------------------
   // Round-robin pick: scan from last+1 upward with wrap; first hit wins.
   // Starting at k=1 means the previous winner is checked last.
   //---------------------------------------------------------------------------
   always_comb begin
      w_any   = |req;
      w_found = 1'b0;
      w_win   = '0;
      w_sel   = '0;
      v_idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         v_idx = (int'(r_last) + k) % NREQ;
         w_sel = C_ID_W'(v_idx);
         if (!w_found && req[w_sel]) begin
            w_found = 1'b1;
            w_win   = w_sel;
         end
      end
   end

   assign w_timeout = (r_cnt == C_CNT_W'(TIMEOUT));

   //---------------------------------------------------------------------------
   // FSM state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // FSM next-state
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_any) w_state_nxt = S_LOAD;
         S_LOAD: w_state_nxt = S_WAIT;
         S_WAIT: if (mul_valid || w_timeout) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         r_last  <= C_ID_W'(NREQ - 1);
         r_id    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_signd <= 1'b0;
         r_lo    <= '0;
         r_prod  <= '0;
         r_z     <= 1'b0;
         r_s     <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_id    <= w_win;
                  r_a     <= req_a[w_win*DATA_WL +: DATA_WL];
                  r_b     <= req_b[w_win*DATA_WL +: DATA_WL];
                  r_signd <= req_signd[w_win];
               end
            end
            S_LOAD: begin
               r_cnt <= '0;
            end
            S_WAIT: begin
               if (mul_valid) begin
                  // High half arrives with valid; low half was captured
                  // on the preceding non-valid cycle.
                  r_prod <= {mul_p, r_lo};
                  r_z    <= mul_z;
                  r_s    <= mul_s;
                  r_err  <= 1'b0;
                  r_last <= r_id;
               end else begin
                  r_lo <= mul_p;
                  if (w_timeout) begin
                     r_prod <= '0;
                     r_z    <= 1'b0;
                     r_s    <= 1'b0;
                     r_err  <= 1'b1;
                     r_last <= r_id;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Outputs: decoded from registered state so reset clears them at once.
   //---------------------------------------------------------------------------
   always_comb begin
      ack = '0;
      if (r_state == S_DONE) ack[r_id] = 1'b1;
   end

   assign rsp_prod  = (r_state == S_DONE) ? r_prod : '0;
   assign rsp_z     = (r_state == S_DONE) & r_z;
   assign rsp_s     = (r_state == S_DONE) & r_s;
   assign rsp_err   = (r_state == S_DONE) & r_err;
   assign busy      = (r_state != S_IDLE);
   assign mul_ld    = (r_state == S_LOAD);
   assign mul_a     = r_a;
   assign mul_b     = r_b;
   assign mul_signd = r_signd;

endmodule

`default_nettype wire
